// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock,
// with valid/ready handshakes on both sides and a sticky overflow flag.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      x,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int SW = WIDTH + 4*DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   shreg, shreg_nxt, adj;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            ovf, ovf_nxt;

  // Add-3 correction on every digit in parallel, including the top digit, so
  // that the bit shifted out of the top is exactly the decimal carry.
  always_comb begin
    adj = shreg;
    for (int k = 0; k < DIGITS; k++) begin
      if (shreg[WIDTH+4*k +: 4] >= 4'd5)
        adj[WIDTH+4*k +: 4] = shreg[WIDTH+4*k +: 4] + 4'd3;
    end
  end

  // NOTE: every signal written here gets a default first, otherwise a path
  // that skips an assignment would infer a latch.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = SHIFT;
          shreg_nxt = SW'(x);
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
        end
      end
      SHIFT: begin
        shreg_nxt = {adj[SW-2:0], 1'b0};
        ovf_nxt   = ovf | adj[SW-1];
        cnt_nxt   = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1))
          state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // Combinational out_ready -> in_ready path enables back-to-back loads.
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            state_nxt = SHIFT;
            shreg_nxt = SW'(x);
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

  assign bcd      = shreg[SW-1 -: 4*DIGITS];
  assign overflow = ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: scoreboarded 8/3 instance plus directed
// checks on an 8/2 (overflow) and a 16/5 (wide) instance.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Reference: decimal digits of v, bit 20 set when v does not fit in d digits.
  function automatic logic [20:0] exp_bcd(input int v, input int d);
    logic [20:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    r[20] = (t != 0);
    return r;
  endfunction

  // Main instance 8/3
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  x = '0;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] bcd;
  logic        overflow;
  int          rdy_mode = 0;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .bcd(bcd), .overflow(overflow)
  );

  // Overflow instance 8/2
  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [7:0]  x2 = '0;
  logic        out_valid2;
  logic        out_ready2 = 1'b1;
  logic [7:0]  bcd2;
  logic        overflow2;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .x(x2),
    .out_valid(out_valid2), .out_ready(out_ready2), .bcd(bcd2), .overflow(overflow2)
  );

  // Wide instance 16/5
  logic        in_valid3 = 1'b0;
  logic        in_ready3;
  logic [15:0] x3 = '0;
  logic        out_valid3;
  logic        out_ready3 = 1'b1;
  logic [19:0] bcd3;
  logic        overflow3;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .x(x3),
    .out_valid(out_valid3), .out_ready(out_ready3), .bcd(bcd3), .overflow(overflow3)
  );

  // Consumer: always ready, or ready about 3 cycles in 4.
  always begin
    @(posedge clk);
    #1;
    out_ready = (rdy_mode != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Scoreboard monitor, sampling on the falling edge.
  logic [20:0] exp_q[$];
  int          acc_q[$];
  logic [20:0] e_mon;
  logic [11:0] hold_bcd;
  logic        hold_ovf;
  bit          held = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      held = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(exp_bcd(int'(x), 3));
        acc_q.push_back(cyc + 1);
      end
      if (out_valid) begin
        if (held) begin
          check("hold_bcd", 32'(bcd), 32'(hold_bcd));
          check("hold_ovf", 32'(overflow), 32'(hold_ovf));
        end else if (acc_q.size() > 0) begin
          check("latency", 32'(cyc - acc_q[0]), 32'd8);
        end
        if (out_ready) begin
          check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e_mon = exp_q.pop_front();
            void'(acc_q.pop_front());
            check("bcd", 32'(bcd), 32'(e_mon[11:0]));
            check("ovf", 32'(overflow), 32'(e_mon[20]));
          end
          held = 1'b0;
        end else begin
          held     = 1'b1;
          hold_bcd = bcd;
          hold_ovf = overflow;
        end
      end
    end
  end

  // Offer v on the main instance until accepted; returns #1 after acceptance.
  task automatic send(input int v);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    x        = 8'(v);
    in_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    check("accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic conv2(input int v);
    int          n;
    logic [20:0] e;
    n = 0;
    e = exp_bcd(v, 2);
    check("u2_ready", 32'(in_ready2), 32'd1);
    x2 = 8'(v);
    in_valid2 = 1'b1;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    while (!out_valid2 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("u2_latency", 32'(n), 32'd8);
    check("u2_bcd", 32'(bcd2), 32'(e[7:0]));
    check("u2_ovf", 32'(overflow2), 32'(e[20]));
    @(posedge clk);
    #1;
  endtask

  task automatic conv3(input int v);
    int          n;
    logic [20:0] e;
    n = 0;
    e = exp_bcd(v, 5);
    check("u3_ready", 32'(in_ready3), 32'd1);
    x3 = 16'(v);
    in_valid3 = 1'b1;
    @(posedge clk);
    #1;
    in_valid3 = 1'b0;
    while (!out_valid3 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("u3_latency", 32'(n), 32'd16);
    check("u3_bcd", 32'(bcd3), 32'(e[19:0]));
    check("u3_ovf", 32'(overflow3), 32'(e[20]));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() > 0 || out_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int vals[3];
    int acc_at[3];
    logic a;
    vals = '{99, 100, 200};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Directed values
    send(0);
    send(255);
    send(137);
    drain();

    // Exhaustive with random consumer stalls and producer gaps
    rdy_mode = 1;
    for (int v = 0; v < 256; v++) begin
      send(v);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    rdy_mode = 0;
    drain();

    // Back-to-back with in_valid held high
    x        = 8'(vals[0]);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int n;
      n = 0;
      a = 1'b0;
      while (!a && n < 40) begin
        @(negedge clk);
        a = in_ready;
        if (i > 0) check("b2b_ready_only_done", 32'(in_ready), 32'(out_valid));
        @(posedge clk);
        #1;
        n++;
      end
      check("b2b_accept", 32'(a), 32'd1);
      acc_at[i] = cyc;
      if (i < 2) x = 8'(vals[i+1]);
    end
    in_valid = 1'b0;
    check("b2b_spacing_1", 32'(acc_at[1] - acc_at[0]), 32'd9);
    check("b2b_spacing_2", 32'(acc_at[2] - acc_at[1]), 32'd9);
    drain();

    // Reset three cycles into SHIFT discards the conversion
    send(77);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_bcd", 32'(bcd), 32'd0);
    send(42);
    drain();

    // Overflow and wide configurations
    conv2(99);
    conv2(100);
    conv2(255);
    conv3(65535);
    conv3(10000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
